jtframe_ram_streamer: RTL and testbench

//  Reader for one port of a dual-port RAM (jtframe_dual_ram_cen, cen tied high).
//  On a start command it reads len consecutive words from base and streams them
//  out on a valid/ready interface. Data is not lost under back-pressure, and

---
 rtl/jtframe_ram_streamer.sv | 147 ++++++++++++++
 tb/tb_jtframe_ram_streamer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ram_streamer.sv
// jtframe_ram_streamer
// Streams len consecutive words, starting at base, out of the read port of a
// synchronous dual-port RAM (one-cycle read latency) onto a valid/ready stream.
// A 2-entry skid buffer absorbs the read latency, so the stream keeps
// 1 word/cycle under continuous ready and never loses a word under back-pressure.
module jtframe_ram_streamer #(
   parameter int dw = 8,
   parameter int aw = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [aw-1:0] base,
   input  logic [aw:0]   len,
   output logic          busy,
   output logic          done,
   output logic [aw-1:0] ram_addr,
   input  logic [dw-1:0] ram_q,
   output logic [dw-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [aw-1:0] addr_q, addr_d;
   logic [aw:0]   rem_q, rem_d;
   logic          inflight_q, inflight_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [dw-1:0] head_q, head_d;
   logic [dw-1:0] skid_q, skid_d;

   logic          pop;
   logic          push;
   logic          issue;
   logic [1:0]    occ;

   // A word leaves when the head is valid and accepted; a word arrives one
   // cycle after a read was issued.
   assign pop  = (cnt_q != 2'd0) && out_ready;
   assign push = inflight_q;

   // Words that will still need a slot once this cycle's pop is accounted for.
   // Counting the pop keeps full throughput; a new read may only be issued when
   // a slot is guaranteed for it, so the skid entry can never overflow.
   assign occ   = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
   assign issue = (state_q == RUN) && (rem_q != '0) && (occ <= 2'd1);

   // Next-state logic for the command FSM and the read address generator.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      inflight_d = issue;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d = RUN;
                  addr_d  = base;
                  rem_d   = len;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            if (issue) begin
               addr_d = addr_q + aw'(1);
               rem_d  = rem_q - (aw+1)'(1);
               if (rem_q == (aw+1)'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == 2'd0 && !inflight_q) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Skid buffer update: head feeds the stream, skid holds a word that
   // returned while the head was stalled.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      skid_d = skid_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = ram_q;
               cnt_d  = 2'd1;
            end else begin
               skid_d = ram_q;
               cnt_d  = 2'd2;
            end
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = skid_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd2) begin
               head_d = skid_q;
               skid_d = ram_q;
            end else begin
               head_d = ram_q;
            end
         end
         default: ;
      endcase
   end

   // State registers; reset abandons any stream and drops in-flight reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == FIN);
   assign ram_addr  = addr_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q;

endmodule

// File: tb/tb_jtframe_ram_streamer.sv
// Bench for jtframe_ram_streamer with aw=4, dw=8 and a read-first RAM model.
module tb_jtframe_ram_streamer;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   logic [DW-1:0] mem [DEPTH];

   int err_n = 0;
   int chk_n = 0;

   jtframe_ram_streamer #(.dw(DW), .aw(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base     (base),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .ram_addr (ram_addr),
      .ram_q    (ram_q),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Synchronous RAM read port, one cycle of latency.
   always @(posedge clk) ram_q <= mem[ram_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},      busy,      0);
      chk({tag, "_done"},      done,      0);
      chk({tag, "_ram_addr"},  ram_addr,  0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"},  out_data,  0);
   endtask

   // Issue one command and follow it to completion. The expected stream is
   // simply mem[(b+i) mod DEPTH] for i in 0..l-1.
   task automatic run_cmd(input int b, input int l, input int rmode, input bit dup,
                          output int first_w, output int last_w);
      int   exp_q[$];
      int   got_q[$];
      int   c, done_n, first_v, done_c, last_c, nmin;
      logic pend;
      logic [DW-1:0] pdata;
      for (int i = 0; i < l; i++) exp_q.push_back(int'(mem[(b + i) % DEPTH]));
      @(negedge clk);
      start = 1'b1; base = AW'(b); len = (AW+1)'(l); out_ready = 1'b1;
      c = 0; done_n = 0; first_v = -1; done_c = -1; last_c = -1; pend = 1'b0; pdata = '0;
      while (c < 400 && !(done_c >= 0 && c > done_c + 2)) begin
         @(negedge clk);
         c++;
         start = 1'b0;
         if (dup && c == 1) begin
            start = 1'b1; base = AW'(9); len = (AW+1)'(5);
         end
         out_ready = (rmode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (pend) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", out_data, pdata);
         end
         if (c == 1) chk("busy_after_start", busy, (l != 0));
         if (out_valid && first_v < 0) first_v = c;
         if (out_valid && out_ready) begin
            got_q.push_back(int'(out_data));
            last_c = c;
         end
         pend  = out_valid && !out_ready;
         pdata = out_data;
         if (done) begin
            done_n++;
            if (done_c < 0) begin
               done_c = c;
               chk("busy_at_done", busy, 0);
               chk("words_before_done", got_q.size(), l);
            end
         end
      end
      chk("done_pulses", done_n, 1);
      chk("word_count", got_q.size(), l);
      nmin = (got_q.size() < l) ? got_q.size() : l;
      for (int i = 0; i < nmin; i++) chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
      if (l == 0) begin
         chk("len0_done_cycle", done_c, 1);
         chk("len0_no_valid", first_v, -1);
      end else if (rmode == 0) begin
         chk("first_valid_cycle", first_v, 3);
         chk("gapless_stream", last_c - first_v, l - 1);
      end
      first_w = (got_q.size() > 0) ? got_q[0] : -1;
      last_w  = (got_q.size() > 0) ? got_q[got_q.size()-1] : -1;
   endtask

   typedef struct {
      int b;
      int l;
      int rmode;
      bit dup;
      int exp_first;
      int exp_last;
   } vec_t;

   initial begin
      vec_t vecs [6];
      int   fw, lw, n;
      bit   reached;

      vecs[0] = '{b: 2,  l: 3,  rmode: 0, dup: 1'b0, exp_first: 2,  exp_last: 4};
      vecs[1] = '{b: 14, l: 4,  rmode: 0, dup: 1'b0, exp_first: 14, exp_last: 1};
      vecs[2] = '{b: 0,  l: 16, rmode: 1, dup: 1'b0, exp_first: 0,  exp_last: 15};
      vecs[3] = '{b: 5,  l: 0,  rmode: 0, dup: 1'b0, exp_first: -1, exp_last: -1};
      vecs[4] = '{b: 3,  l: 4,  rmode: 0, dup: 1'b1, exp_first: 3,  exp_last: 6};
      vecs[5] = '{b: 7,  l: 16, rmode: 0, dup: 1'b0, exp_first: 7,  exp_last: 6};

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed table of commands
      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].b, vecs[i].l, vecs[i].rmode, vecs[i].dup, fw, lw);
         chk($sformatf("vec%0d_first", i), fw, vecs[i].exp_first);
         chk($sformatf("vec%0d_last", i), lw, vecs[i].exp_last);
      end

      // Reset in the middle of a stream, then a fresh short command
      @(negedge clk);
      start = 1'b1; base = '0; len = (AW+1)'(8); out_ready = 1'b1;
      n = 0; reached = 1'b0;
      for (int c = 0; c < 50 && !reached; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && out_ready) n++;
         if (n == 2) reached = 1'b1;
      end
      chk("midstream_two_words", reached, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      chk_reset_outputs("held_rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("post_rst");
      run_cmd(0, 2, 0, 1'b0, fw, lw);
      chk("after_rst_first", fw, 0);
      chk("after_rst_last", lw, 1);

      // Randomized commands on random RAM contents
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
      for (int t = 0; t < 20; t++) begin
         int  rb, rl, rm;
         bit  rd;
         rb = $urandom_range(0, DEPTH - 1);
         rl = $urandom_range(0, DEPTH);
         rm = $urandom_range(0, 1);
         rd = (rl > 0) && ($urandom_range(0, 3) == 0);
         run_cmd(rb, rl, rm, rd, fw, lw);
      end

      $display("Result: errors=%0d of %0d checks", err_n, chk_n);
      $finish;
   end

endmodule
